// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the APB bridge arbiter slice.
//   apb_state_e : shared-port transfer state (IDLE/SETUP/ACCESS)
//   DEF_*       : default widths for the arbiter parameters
//   grant_wd()  : width of a requester index, never below one bit
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_WD = 32;
  localparam int unsigned DEF_DATA_WD = 32;
  localparam int unsigned DEF_STRB_WD = 4;
  localparam int unsigned DEF_PROT_WD = 3;

  // A single requester still needs a one-bit index register.
  function automatic int unsigned grant_wd(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index of the previously served requester
//   grant_c     : one-hot grant (all zero when nothing requests)
//   grant_idx_c : encoded grant index (0 when nothing requests)
module rr_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = grant_wd(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] grant_idx_c
);

  logic [2*N-1:0] req_dbl;
  logic [31:0]    base;
  logic [31:0]    pos;
  logic           found;

  // Upper copy of the request vector provides the wrap-around search.
  assign req_dbl = {req, req};

  // First set bit at or above last_grant+1 in the doubled vector, folded back.
  always_comb begin
    base  = (32'(last_grant) + 32'd1) % 32'(N);
    found = 1'b0;
    pos   = 32'd0;
    for (int unsigned k = 0; k < 2 * N; k++) begin
      if (!found && (k >= base) && req_dbl[k]) begin
        found = 1'b1;
        pos   = k;
      end
    end
    if (pos >= 32'(N)) begin
      pos = pos - 32'(N);
    end
    grant_idx_c = IW'(pos);
    grant_c     = found ? (N'(1) << pos) : '0;
  end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Shares one APB master port between NUM_REQ APB requesters, round-robin,
// one transfer in flight. The granted command is captured in IDLE and
// re-issued from registers so the shared port is stable for the bridge.
//   a_pclk, a_prst_n : clock, async active-low reset
//   s_*              : flattened requester ports (requester i at [i*W +: W])
//   m_*              : shared master port towards the bridge
//   grant_id         : current or most recent grant (debug)
//   busy             : transfer in progress (SETUP or ACCESS)
module apb_bridge_arbiter
  import apb_bridge_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned ADDR_WD = DEF_ADDR_WD,
  parameter  int unsigned DATA_WD = DEF_DATA_WD,
  parameter  int unsigned STRB_WD = DEF_STRB_WD,
  parameter  int unsigned PROT_WD = DEF_PROT_WD,
  localparam int unsigned GNT_WD  = grant_wd(NUM_REQ)
) (
  input  logic                       a_pclk,
  input  logic                       a_prst_n,
  input  logic [NUM_REQ-1:0]         s_psel,
  input  logic [NUM_REQ-1:0]         s_penable,
  input  logic [NUM_REQ-1:0]         s_pwrite,
  input  logic [NUM_REQ*ADDR_WD-1:0] s_paddr,
  input  logic [NUM_REQ*DATA_WD-1:0] s_pwdata,
  input  logic [NUM_REQ*PROT_WD-1:0] s_pprot,
  input  logic [NUM_REQ*STRB_WD-1:0] s_pstrb,
  output logic [NUM_REQ*DATA_WD-1:0] s_prdata,
  output logic [NUM_REQ-1:0]         s_pready,
  output logic                       m_psel,
  output logic                       m_penable,
  output logic                       m_pwrite,
  output logic [ADDR_WD-1:0]         m_paddr,
  output logic [DATA_WD-1:0]         m_pwdata,
  output logic [PROT_WD-1:0]         m_pprot,
  output logic [STRB_WD-1:0]         m_pstrb,
  input  logic [DATA_WD-1:0]         m_prdata,
  input  logic                       m_pready,
  output logic [GNT_WD-1:0]          grant_id,
  output logic                       busy
);

  apb_state_e          state_q;
  apb_state_e          state_d;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [GNT_WD-1:0]   gnt_idx;
  logic [GNT_WD-1:0]   last_grant_q;
  logic                load_cmd;
  logic                xfer_done;
  logic                sel_pwrite;
  logic [ADDR_WD-1:0]  sel_paddr;
  logic [DATA_WD-1:0]  sel_pwdata;
  logic [PROT_WD-1:0]  sel_pprot;
  logic [STRB_WD-1:0]  sel_pstrb;
  logic                unused_penable;

  // Requester penable carries no arbitration information.
  assign unused_penable = ^s_penable;

  // A requester asks for the shared port simply by raising psel.
  assign req = s_psel;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (GNT_WD)
  ) u_rr_arbiter (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_c     (gnt_onehot),
    .grant_idx_c (gnt_idx)
  );

  // Command of the arbitration winner.
  always_comb begin
    sel_pwrite = 1'b0;
    sel_paddr  = '0;
    sel_pwdata = '0;
    sel_pprot  = '0;
    sel_pstrb  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_pwrite = s_pwrite[i];
        sel_paddr  = s_paddr[i*ADDR_WD +: ADDR_WD];
        sel_pwdata = s_pwdata[i*DATA_WD +: DATA_WD];
        sel_pprot  = s_pprot[i*PROT_WD +: PROT_WD];
        sel_pstrb  = s_pstrb[i*STRB_WD +: STRB_WD];
      end
    end
  end

  // State register.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State decode: capture strobes and routing of the response to the owner.
  always_comb begin
    load_cmd  = 1'b0;
    xfer_done = 1'b0;
    s_pready  = '0;
    s_prdata  = '0;
    case (state_q)
      IDLE: load_cmd = |req;
      ACCESS: begin
        xfer_done = m_pready;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (32'(grant_id) == i) begin
            s_pready[i]                    = m_pready;
            s_prdata[i*DATA_WD +: DATA_WD] = m_prdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Shared-port registers; command fields only change on a new grant.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      m_psel       <= 1'b0;
      m_penable    <= 1'b0;
      busy         <= 1'b0;
      m_pwrite     <= 1'b0;
      m_paddr      <= '0;
      m_pwdata     <= '0;
      m_pprot      <= '0;
      m_pstrb      <= '0;
      grant_id     <= '0;
      last_grant_q <= GNT_WD'(NUM_REQ - 1);
    end else begin
      m_psel    <= (state_d != IDLE);
      m_penable <= (state_d == ACCESS);
      busy      <= (state_d != IDLE);
      if (load_cmd) begin
        m_pwrite <= sel_pwrite;
        m_paddr  <= sel_paddr;
        m_pwdata <= sel_pwdata;
        m_pprot  <= sel_pprot;
        m_pstrb  <= sel_pstrb;
        grant_id <= gnt_idx;
      end
      if (xfer_done) begin
        last_grant_q <= grant_id;
      end
    end
  end

endmodule
